multicycle_ctrl: RTL and testbench

Moore-style control FSM that sequences the shared multicycle RV32I datapath: memory, IR, PC, ALU and register file. It decodes opcode/funct fields and drives every datapath mux select and write strobe, including the 3-bit ImmSrc select for the immediate extender. It stalls on a memory ready handshake and latches a sticky illegal-instruction flag.

---
 rtl/multicycle_ctrl_pkg.sv | 51 +++++
 rtl/ctrl_imm_src_dec.sv | 21 ++
 rtl/multicycle_ctrl.sv | 153 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_LUI      = 4'd10,
        S_BRANCH   = 4'd11,
        S_ILLEGAL  = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b101;
    localparam logic [2:0] IMM_U = 3'b010;
    localparam logic [2:0] IMM_J = 3'b110;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/ctrl_imm_src_dec.sv
// Opcode -> immediate-extender format select; purely combinational.
module ctrl_imm_src_dec
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] imm_src
);

    // Unknown opcodes fall back to the I format so the extender stays benign.
    always_comb begin
        imm_src = IMM_I;
        case (opcode)
            OP_STORE:  imm_src = IMM_S;
            OP_BRANCH: imm_src = IMM_B;
            OP_LUI:    imm_src = IMM_U;
            OP_JAL:    imm_src = IMM_J;
            default:   imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM sequencing the shared multicycle RV32I datapath.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               ir_write,
    output logic               adr_src,
    output logic               mem_write,
    output logic               reg_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [2:0]         imm_src,
    output logic               illegal_instr,
    output logic [STATE_W-1:0] state_o
);

    state_t state, next_state;
    logic   illegal_q;
    logic   pc_write_c, ir_write_c, mem_write_c, reg_write_c;

    ctrl_imm_src_dec u_imm_dec (
        .opcode  (opcode),
        .imm_src (imm_src)
    );

    // State register; the illegal flag sets on entry to ILLEGAL and only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == S_ILLEGAL) illegal_q <= 1'b1;
        end
    end

    // Next-state and Moore outputs; unlisted selects stay at their zero encoding.
    always_comb begin
        next_state  = S_FETCH;
        adr_src     = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RD2;
        alu_op      = ALUOP_ADD;
        pc_write_c  = 1'b0;
        ir_write_c  = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        case (state)
            S_FETCH: begin
                result_src = RES_ALURES;
                alu_src_b  = SRCB_FOUR;
                ir_write_c = mem_ready;
                pc_write_c = mem_ready;
                next_state = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // OldPC + imm lands in ALUOut as the branch/jump target.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE:          next_state = S_EXECUTER;
                    OP_ITYPE:          next_state = S_EXECUTEI;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    OP_LUI:            next_state = S_LUI;
                    default:           next_state = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = SRCA_RD1;
                alu_src_b  = SRCB_IMM;
                next_state = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                next_state = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src  = RES_DATA;
                reg_write_c = 1'b1;
                next_state  = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_c = 1'b1;
                next_state  = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                alu_src_a  = SRCA_RD1;
                alu_src_b  = SRCB_RD2;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a  = SRCA_RD1;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                next_state  = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target from ALUOut while the ALU forms OldPC+4 for the link.
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                pc_write_c = 1'b1;
                next_state = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a  = SRCA_ZERO;
                alu_src_b  = SRCB_IMM;
                next_state = S_ALUWB;
            end
            S_BRANCH: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_RD2;
                alu_op    = ALUOP_SUB;
                // Only beq/bne are supported; funct3[0] inverts the zero test.
                if (funct3[2:1] == 2'b00) begin
                    pc_write_c = zero ^ funct3[0];
                    next_state = S_FETCH;
                end else begin
                    next_state = S_ILLEGAL;
                end
            end
            S_ILLEGAL: next_state = S_ILLEGAL;
            default:   next_state = S_FETCH;
        endcase
    end

    // Strobes are gated by rst_n so nothing fires combinationally during reset.
    assign pc_write      = pc_write_c  & rst_n;
    assign ir_write      = ir_write_c  & rst_n;
    assign mem_write     = mem_write_c & rst_n;
    assign reg_write     = reg_write_c & rst_n;
    assign illegal_instr = illegal_q;
    assign state_o       = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle output vectors per instruction class.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, ir_write, adr_src, mem_write, reg_write, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0] imm_src;
    logic [3:0] state_o;

    int errors = 0;
    int checks = 0;

    multicycle_ctrl #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
        .adr_src(adr_src), .mem_write(mem_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .imm_src(imm_src), .illegal_instr(illegal_instr),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    // {state, pc_write, ir_write, adr_src, mem_write, reg_write, result_src, a, b, alu_op, imm_src}
    wire [19:0] snap = {state_o, pc_write, ir_write, adr_src, mem_write, reg_write,
                        result_src, alu_src_a, alu_src_b, alu_op, imm_src};

    function automatic logic [19:0] ex(int st, int pcw, int irw, int adr, int mw, int rw,
                                       int rs, int a, int b, int op, int imm);
        return {4'(st), 1'(pcw), 1'(irw), 1'(adr), 1'(mw), 1'(rw),
                2'(rs), 2'(a), 2'(b), 2'(op), 3'(imm)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; opcode = 7'd0; funct3 = 3'd0; zero = 1'b0;
        tick(); tick();
        checks++;
        if (snap !== ex(S_FETCH, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0)) begin
            errors++; $display("FAIL reset_hold: got %h expected %h", snap, ex(S_FETCH, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0));
        end
        checks++;
        if (illegal_instr !== 1'b0) begin
            errors++; $display("FAIL reset_illegal: got %b expected 0", illegal_instr);
        end
        rst_n = 1'b1; #1;
        checks++;
        if ({ir_write, pc_write} !== 2'b11) begin
            errors++; $display("FAIL reset_release_strobes: got %b expected 11", {ir_write, pc_write});
        end
        mem_ready = 1'b0;
        tick();
        checks++;
        if (state_o !== 4'(S_FETCH)) begin
            errors++; $display("FAIL fetch_stall: got %0d expected %0d", state_o, S_FETCH);
        end
    endtask

    task automatic test_add();
        logic [19:0] e [5];
        bit          mr [5];
        opcode = OP_RTYPE; funct3 = 3'd0;
        e = '{ex(S_FETCH, 1, 1, 0, 0, 0, 2, 0, 2, 0, 0), ex(S_DECODE, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0),
              ex(S_EXECUTER, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0), ex(S_ALUWB, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0),
              ex(S_FETCH, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0)};
        mr = '{1, 1, 1, 1, 0};
        for (int i = 0; i < 5; i++) begin
            mem_ready = mr[i]; #1;
            checks++;
            if (snap !== e[i]) begin errors++; $display("FAIL add step %0d: got %h expected %h", i, snap, e[i]); end
            tick();
        end
    endtask

    task automatic test_lw_stall();
        logic [19:0] e [9];
        bit          mr [9];
        opcode = OP_LOAD; funct3 = 3'b010;
        e = '{ex(S_FETCH, 1, 1, 0, 0, 0, 2, 0, 2, 0, 0), ex(S_DECODE, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0),
              ex(S_MEMADR, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0), ex(S_MEMREAD, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0),
              ex(S_MEMREAD, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), ex(S_MEMREAD, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0),
              ex(S_MEMREAD, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), ex(S_MEMWB, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0),
              ex(S_FETCH, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0)};
        mr = '{1, 1, 0, 0, 0, 0, 1, 1, 0};
        for (int i = 0; i < 9; i++) begin
            mem_ready = mr[i]; #1;
            checks++;
            if (snap !== e[i]) begin errors++; $display("FAIL lw step %0d: got %h expected %h", i, snap, e[i]); end
            tick();
        end
    endtask

    task automatic test_branch();
        logic [19:0] e [4];
        // beq taken (zero=1), then bne not taken (zero=1)
        for (int k = 0; k < 2; k++) begin
            opcode = OP_BRANCH; funct3 = 3'(k); zero = 1'b1;
            e = '{ex(S_FETCH, 1, 1, 0, 0, 0, 2, 0, 2, 0, 5), ex(S_DECODE, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5),
                  ex(S_BRANCH, (k == 0) ? 1 : 0, 0, 0, 0, 0, 0, 2, 0, 1, 5),
                  ex(S_FETCH, 0, 0, 0, 0, 0, 2, 0, 2, 0, 5)};
            for (int i = 0; i < 4; i++) begin
                mem_ready = (i < 3); #1;
                checks++;
                if (snap !== e[i]) begin
                    errors++; $display("FAIL %s step %0d: got %h expected %h", (k == 0) ? "beq" : "bne", i, snap, e[i]);
                end
                tick();
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jal_lui();
        logic [19:0] e [5];
        opcode = OP_JAL; funct3 = 3'd0;
        e = '{ex(S_FETCH, 1, 1, 0, 0, 0, 2, 0, 2, 0, 6), ex(S_DECODE, 0, 0, 0, 0, 0, 0, 1, 1, 0, 6),
              ex(S_JAL, 1, 0, 0, 0, 0, 0, 1, 2, 0, 6), ex(S_ALUWB, 0, 0, 0, 0, 1, 0, 0, 0, 0, 6),
              ex(S_FETCH, 0, 0, 0, 0, 0, 2, 0, 2, 0, 6)};
        for (int i = 0; i < 5; i++) begin
            mem_ready = (i < 4); #1;
            checks++;
            if (snap !== e[i]) begin errors++; $display("FAIL jal step %0d: got %h expected %h", i, snap, e[i]); end
            tick();
        end
        opcode = OP_LUI;
        e = '{ex(S_FETCH, 1, 1, 0, 0, 0, 2, 0, 2, 0, 2), ex(S_DECODE, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2),
              ex(S_LUI, 0, 0, 0, 0, 0, 0, 3, 1, 0, 2), ex(S_ALUWB, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2),
              ex(S_FETCH, 0, 0, 0, 0, 0, 2, 0, 2, 0, 2)};
        for (int i = 0; i < 5; i++) begin
            mem_ready = (i < 4); #1;
            checks++;
            if (snap !== e[i]) begin errors++; $display("FAIL lui step %0d: got %h expected %h", i, snap, e[i]); end
            tick();
        end
    endtask

    task automatic test_sw_stall();
        logic [19:0] e [7];
        bit          mr [7];
        opcode = OP_STORE; funct3 = 3'b010;
        e = '{ex(S_FETCH, 1, 1, 0, 0, 0, 2, 0, 2, 0, 1), ex(S_DECODE, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1),
              ex(S_MEMADR, 0, 0, 0, 0, 0, 0, 2, 1, 0, 1), ex(S_MEMWRITE, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1),
              ex(S_MEMWRITE, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1), ex(S_MEMWRITE, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1),
              ex(S_FETCH, 0, 0, 0, 0, 0, 2, 0, 2, 0, 1)};
        mr = '{1, 1, 0, 0, 0, 1, 0};
        for (int i = 0; i < 7; i++) begin
            mem_ready = mr[i]; #1;
            checks++;
            if (snap !== e[i]) begin errors++; $display("FAIL sw step %0d: got %h expected %h", i, snap, e[i]); end
            tick();
        end
    endtask

    task automatic test_abort();
        // Store stalled in MEMWRITE, then reset mid-instruction.
        opcode = OP_STORE; mem_ready = 1'b1;
        tick(); tick();
        mem_ready = 1'b0;
        tick();
        checks++;
        if ({state_o, mem_write} !== {4'(S_MEMWRITE), 1'b1}) begin
            errors++; $display("FAIL abort_pre: got %h expected %h", {state_o, mem_write}, {4'(S_MEMWRITE), 1'b1});
        end
        mem_ready = 1'b1;
        rst_n = 1'b0; #1;
        checks++;
        if ({state_o, mem_write, pc_write, ir_write} !== {4'(S_FETCH), 3'b000}) begin
            errors++; $display("FAIL abort_reset: got %h expected %h", {state_o, mem_write, pc_write, ir_write}, {4'(S_FETCH), 3'b000});
        end
        mem_ready = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_illegal();
        opcode = 7'b1111111; funct3 = 3'd0;
        mem_ready = 1'b1;
        tick();
        checks++;
        if (snap !== ex(S_DECODE, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0)) begin
            errors++; $display("FAIL illegal_decode: got %h expected %h", snap, ex(S_DECODE, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({illegal_instr, snap} !== {1'b1, ex(S_ILLEGAL, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)}) begin
                errors++; $display("FAIL illegal_hold %0d: got %h expected %h", i, {illegal_instr, snap},
                                   {1'b1, ex(S_ILLEGAL, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
            end
        end
        rst_n = 1'b0; #1;
        checks++;
        if ({illegal_instr, state_o} !== {1'b0, 4'(S_FETCH)}) begin
            errors++; $display("FAIL illegal_clear: got %h expected %h", {illegal_instr, state_o}, {1'b0, 4'(S_FETCH)});
        end
        opcode = OP_RTYPE;
        rst_n = 1'b1; #1;
        checks++;
        if ({ir_write, pc_write, illegal_instr} !== 3'b110) begin
            errors++; $display("FAIL illegal_resume: got %b expected 110", {ir_write, pc_write, illegal_instr});
        end
        tick();
        checks++;
        if (state_o !== 4'(S_DECODE)) begin
            errors++; $display("FAIL illegal_resume_decode: got %0d expected %0d", state_o, S_DECODE);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_stall();
        test_branch();
        test_jal_lui();
        test_sw_stall();
        test_abort();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
